// File: rtl/legv8_isa_pkg.sv
// LEGv8 ISA constants shared by the encoder, the loader and the control decoder.
package legv8_isa_pkg;

  // Symbolic operations accepted by the loader; codes 11..15 are rejected.
  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_ORR  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_ADDI = 4'd4,
    OP_SUBI = 4'd5,
    OP_MOVZ = 4'd6,
    OP_B    = 4'd7,
    OP_CBZ  = 4'd8,
    OP_LDUR = 4'd9,
    OP_STUR = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

  // Opcode groups, identical to the patterns the control unit decodes.
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  // Legal immediate ranges.
  localparam int IMM_ADDI_MAX = 4095;
  localparam int IMM_DT_MIN   = -256;
  localparam int IMM_DT_MAX   = 255;
  localparam int IMM_CB_MIN   = -(2 ** 18);
  localparam int IMM_CB_MAX   = (2 ** 18) - 1;
  localparam int IMM_MOVZ_MAX = 65535;

endpackage

// File: rtl/legv8_program_loader_if.sv
// Symbolic-instruction handshake between a host and the program loader.
interface legv8_program_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rn;
  logic [4:0]  in_rm;
  logic [25:0] in_imm;
  logic [1:0]  in_hw;

  modport master (
    output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_hw,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_hw,
    output in_ready
  );
endinterface

// File: rtl/legv8_encode.sv
// Combinational LEGv8 encoder: packs symbolic fields into a machine word
// and flags unknown operations or out-of-range immediates.
module legv8_encode
  import legv8_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [25:0] imm,
  input  logic [1:0]  hw,
  output logic [31:0] word,
  output logic        illegal
);

  int simm;
  int uimm;

  // Field packing and immediate range check per operation.
  always_comb begin
    simm    = int'($signed(imm));
    uimm    = int'({6'b0, imm});
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:  word = {OPC_AND, rm, 6'b000000, rn, rd};
      OP_ORR:  word = {OPC_ORR, rm, 6'b000000, rn, rd};
      OP_ADD:  word = {OPC_ADD, rm, 6'b000000, rn, rd};
      OP_SUB:  word = {OPC_SUB, rm, 6'b000000, rn, rd};
      OP_ADDI: begin
        word    = {OPC_ADDI, imm[11:0], rn, rd};
        illegal = uimm > IMM_ADDI_MAX;
      end
      OP_SUBI: begin
        word    = {OPC_SUBI, imm[11:0], rn, rd};
        illegal = uimm > IMM_ADDI_MAX;
      end
      OP_MOVZ: begin
        word    = {OPC_MOVZ, hw, imm[15:0], rd};
        illegal = uimm > IMM_MOVZ_MAX;
      end
      OP_B:    word = {OPC_B, imm};
      OP_CBZ: begin
        word    = {OPC_CBZ, imm[18:0], rd};
        illegal = (simm < IMM_CB_MIN) || (simm > IMM_CB_MAX);
      end
      OP_LDUR: begin
        word    = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
        illegal = (simm < IMM_DT_MIN) || (simm > IMM_DT_MAX);
      end
      OP_STUR: begin
        word    = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
        illegal = (simm < IMM_DT_MIN) || (simm > IMM_DT_MAX);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/legv8_program_loader.sv
// Program loader: accepts symbolic instructions, encodes them and writes
// the words sequentially into instruction memory starting at BASE_ADDR.
module legv8_program_loader
  import legv8_isa_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [63:0] BASE_ADDR  = 64'h0
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          start,
  input  logic                          finish,
  legv8_program_loader_if.slave         in_if,
  output logic                          imem_we,
  output logic [63:0]                   imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic                          err,
  output logic [$clog2(IMEM_DEPTH):0]   count,
  output logic                          done
);

  localparam int CW = $clog2(IMEM_DEPTH) + 1;

  state_e          state_q, state_d;
  logic [63:0]     addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            we_q, we_d;
  logic [63:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;

  logic [31:0]     enc_word;
  logic            enc_illegal;
  logic            accept;
  logic            write_ok;

  legv8_encode u_encode (
    .op      (in_if.in_op),
    .rd      (in_if.in_rd),
    .rn      (in_if.in_rn),
    .rm      (in_if.in_rm),
    .imm     (in_if.in_imm),
    .hw      (in_if.in_hw),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign accept   = in_if.in_valid && (state_q == ST_LOAD);
  assign write_ok = accept && !enc_illegal;

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: start restarts from any state; finish or the last word ends LOAD.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_LOAD;
    end else if (state_q == ST_LOAD) begin
      if (finish || (write_ok && (count_q == CW'(IMEM_DEPTH - 1)))) state_d = ST_DONE;
    end
  end

  // State-decoded outputs.
  always_comb begin
    in_if.in_ready = (state_q == ST_LOAD);
    done           = (state_q == ST_DONE);
  end

  // Write/error staging and address/count bookkeeping; start drops a same-cycle accept.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    if (start) begin
      addr_d  = BASE_ADDR;
      count_d = '0;
    end else if (write_ok) begin
      we_d    = 1'b1;
      waddr_d = addr_q;
      wdata_d = enc_word;
      addr_d  = addr_q + 64'd4;
      count_d = count_q + 1'b1;
    end else if (accept) begin
      err_d   = 1'b1;
    end
  end

  // Datapath and output registers; a write staged at a reset edge is lost.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_legv8_program_loader.sv
// Scoreboard bench for legv8_program_loader: two instances (deep and 4-word)
// share one stimulus stream; a reference model predicts writes and errors.
module tb_legv8_program_loader;
  import legv8_isa_pkg::*;

  logic clk = 1'b0;
  logic rst, start, finish, valid;
  logic [3:0]  op;
  logic [4:0]  rd, rn, rm;
  logic [25:0] imm;
  logic [1:0]  hw;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  legv8_program_loader_if ifa ();
  legv8_program_loader_if ifb ();

  assign ifa.in_valid = valid; assign ifa.in_op = op; assign ifa.in_rd = rd; assign ifa.in_rn = rn;
  assign ifa.in_rm = rm; assign ifa.in_imm = imm; assign ifa.in_hw = hw;
  assign ifb.in_valid = valid; assign ifb.in_op = op; assign ifb.in_rd = rd; assign ifb.in_rn = rn;
  assign ifb.in_rm = rm; assign ifb.in_imm = imm; assign ifb.in_hw = hw;

  logic        we_a, err_a, done_a, we_b, err_b, done_b;
  logic [63:0] addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [6:0]  cnt_a;
  logic [2:0]  cnt_b;

  legv8_program_loader dut_a (
    .CLK(clk), .Reset(rst), .start(start), .finish(finish), .in_if(ifa.slave),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a), .err(err_a),
    .count(cnt_a), .done(done_a)
  );

  legv8_program_loader #(.IMEM_DEPTH(4), .BASE_ADDR(64'h1000)) dut_b (
    .CLK(clk), .Reset(rst), .start(start), .finish(finish), .in_if(ifb.slave),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b), .err(err_b),
    .count(cnt_b), .done(done_b)
  );

  typedef struct {
    int          cyc;
    logic        is_err;
    logic [63:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 loading, 2 done.
  int          m_st[2];
  logic [63:0] m_addr[2];
  int          m_cnt[2];
  int          depth[2] = '{64, 4};
  logic [63:0] base[2]  = '{64'h0, 64'h1000};

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference encoder written from the field layouts with plain arithmetic.
  function automatic void ref_enc(input logic [3:0] o, input int d, input int n, input int m,
                                  input logic [25:0] im, input int h,
                                  output logic [31:0] w, output bit ok);
    longint u, s, r;
    u  = longint'(im);
    s  = (u >= (64'd1 << 25)) ? u - (64'd1 << 26) : u;
    ok = 1'b1;
    r  = 0;
    case (o)
      OP_AND:  r = (longint'(11'b10001010000) << 21) + m * 65536 + n * 32 + d;
      OP_ORR:  r = (longint'(11'b10101010000) << 21) + m * 65536 + n * 32 + d;
      OP_ADD:  r = (longint'(11'b10001011000) << 21) + m * 65536 + n * 32 + d;
      OP_SUB:  r = (longint'(11'b11001011000) << 21) + m * 65536 + n * 32 + d;
      OP_ADDI: begin ok = (u <= 4095); r = (longint'(10'b1001000100) << 22) + ((u % 4096) << 10) + n * 32 + d; end
      OP_SUBI: begin ok = (u <= 4095); r = (longint'(10'b1101000100) << 22) + ((u % 4096) << 10) + n * 32 + d; end
      OP_MOVZ: begin ok = (u <= 65535); r = (longint'(9'b110100101) << 23) + (longint'(h) << 21) + ((u % 65536) << 5) + d; end
      OP_B:    r = (longint'(6'b000101) << 26) + u;
      OP_CBZ:  begin ok = (s >= -262144) && (s <= 262143); r = (longint'(8'b10110100) << 24) + ((s & 64'h7FFFF) << 5) + d; end
      OP_LDUR: begin ok = (s >= -256) && (s <= 255); r = (longint'(11'b11111000010) << 21) + ((s & 64'h1FF) << 12) + n * 32 + d; end
      OP_STUR: begin ok = (s >= -256) && (s <= 255); r = (longint'(11'b11111000000) << 21) + ((s & 64'h1FF) << 12) + n * 32 + d; end
      default: ok = 1'b0;
    endcase
    w = r[31:0];
  endfunction

  // One cycle: check state-level outputs, advance the model, then wait for the next negedge.
  task automatic step();
    exp_t        e;
    logic [31:0] w;
    bit          ok;
    bit          ready;
    #1;
    chk("a_in_ready", ifa.in_ready, m_st[0] == 1);
    chk("a_done",     done_a,       m_st[0] == 2);
    chk("a_count",    cnt_a,        m_cnt[0]);
    chk("b_in_ready", ifb.in_ready, m_st[1] == 1);
    chk("b_done",     done_b,       m_st[1] == 2);
    chk("b_count",    cnt_b,        m_cnt[1]);
    for (int d = 0; d < 2; d++) begin
      ready = (m_st[d] == 1);
      if (rst) begin
        m_st[d] = 0; m_addr[d] = base[d]; m_cnt[d] = 0;
      end else if (start) begin
        m_st[d] = 1; m_addr[d] = base[d]; m_cnt[d] = 0;
      end else begin
        if (valid && ready) begin
          ref_enc(op, int'(rd), int'(rn), int'(rm), imm, int'(hw), w, ok);
          e.cyc = cyc + 1;
          e.is_err = !ok;
          e.addr = ok ? m_addr[d] : 64'h0;
          e.word = ok ? w : 32'h0;
          if (ok) begin m_addr[d] = m_addr[d] + 64'd4; m_cnt[d]++; end
          if (d == 0) qa.push_back(e); else qb.push_back(e);
        end
        if (ready && (finish || m_cnt[d] == depth[d])) m_st[d] = 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic instr(input op_e o, input int d, input int n, input int m, input int v, input int h);
    logic [31:0] t;
    t = v;
    valid = 1'b1; op = o; rd = d[4:0]; rn = n[4:0]; rm = m[4:0]; imm = t[25:0]; hw = h[1:0];
    step();
  endtask

  task automatic idle();
    valid = 1'b0; start = 1'b0; finish = 1'b0;
    step();
  endtask

  function automatic logic [25:0] pick_imm();
    int bnd[14] = '{0, 4095, 4096, 65535, 65536, -256, 255, 256, -257,
                    262143, 262144, -262144, -262145, -1};
    int k;
    logic [31:0] v;
    k = $urandom_range(0, 17);
    v = (k < 14) ? bnd[k] : $urandom;
    return v[25:0];
  endfunction

  // Monitor for the deep instance: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (we_a || err_a) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected actual=we%0b/err%0b required=none", we_a, err_a);
      end else begin
        e = qa.pop_front();
        chk("a_cycle", cyc, e.cyc);
        chk("a_err", err_a, e.is_err);
        chk("a_we", we_a, !e.is_err);
        if (!e.is_err) begin
          chk("a_addr", addr_a, e.addr);
          chk("a_wdata", wdata_a, e.word);
        end
      end
    end
  end

  // Monitor for the 4-word instance.
  always @(negedge clk) begin
    exp_t e;
    if (we_b || err_b) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected actual=we%0b/err%0b required=none", we_b, err_b);
      end else begin
        e = qb.pop_front();
        chk("b_cycle", cyc, e.cyc);
        chk("b_err", err_b, e.is_err);
        chk("b_we", we_b, !e.is_err);
        if (!e.is_err) begin
          chk("b_addr", addr_b, e.addr);
          chk("b_wdata", wdata_b, e.word);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; valid = 1'b0;
    op = '0; rd = '0; rn = '0; rm = '0; imm = '0; hw = '0;
    for (int i = 0; i < 2; i++) begin m_st[i] = 0; m_addr[i] = base[i]; m_cnt[i] = 0; end
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    chk("rst_we", we_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_addr", addr_a, 0);
    idle();

    // Directed program; the 4-word instance fills on the B and refuses CBZ.
    start = 1'b1; step(); start = 1'b0;
    instr(OP_ADD, 1, 2, 3, 0, 0);
    instr(OP_LDUR, 9, 22, 0, 64, 0);
    instr(OP_MOVZ, 5, 0, 0, 32'hBEEF, 1);
    instr(OP_B, 0, 0, 0, -3, 0);
    instr(OP_CBZ, 7, 0, 0, 2, 0);
    instr(OP_ADDI, 1, 2, 0, 4096, 0);
    instr(OP_ADDI, 1, 2, 0, 4095, 0);
    instr(OP_LDUR, 3, 4, 0, -257, 0);
    instr(OP_STUR, 3, 4, 0, -256, 0);
    instr(OP_CBZ, 8, 0, 0, -262145, 0);
    instr(OP_CBZ, 8, 0, 0, -262144, 0);
    valid = 1'b0; finish = 1'b1; step(); finish = 1'b0;
    idle(); idle();

    // Reset at the same edge as an accept: the write is dropped.
    start = 1'b1; step(); start = 1'b0;
    instr(OP_ADD, 4, 5, 6, 0, 0);
    rst = 1'b1; instr(OP_SUB, 7, 8, 9, 0, 0);
    rst = 1'b0; idle();
    chk("post_rst_addr_a", addr_a, 0);
    chk("post_rst_wdata_a", wdata_a, 0);
    chk("post_rst_addr_b", addr_b, 0);
    idle();

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      rst    = ($urandom_range(0, 299) == 0);
      start  = ($urandom_range(0, 24) == 0);
      finish = ($urandom_range(0, 39) == 0);
      valid  = ($urandom_range(0, 3) != 0);
      op     = 4'($urandom_range(0, 15));
      rd     = 5'($urandom); rn = 5'($urandom); rm = 5'($urandom);
      imm    = pick_imm();
      hw     = 2'($urandom);
      step();
    end
    rst = 1'b0;
    idle(); idle(); idle();
    chk("a_drain", qa.size(), 0);
    chk("b_drain", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
